// File: rtl/id_scan_if.sv
// Character-stream bus for the identifier scanner: stimulus side is master, scanner is slave.
interface id_scan_if #(
    parameter int unsigned LEN_W = 4,
    parameter int unsigned CNT_W = 8
);
    logic [7:0]       char;
    logic             char_valid;
    logic             match;
    logic             tok_done;
    logic [LEN_W-1:0] tok_len;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output char, char_valid,
        input  match, tok_done, tok_len, match_cnt
    );

    modport slave (
        input  char, char_valid,
        output match, tok_done, tok_len, match_cnt
    );
endinterface

// File: rtl/id_scan_fsm.sv
// Identifier scanner: accepts tokens of the form letters{MIN_ALPHA,} digits{1,}
// bounded by separators, at most MAX_LEN characters long. Reports each valid
// token with a one-cycle tok_done pulse, its length, and a saturating count.
// Optional build macro: ID_UNDERSCORE_EN classes '_' (code 95) as a letter.
module id_scan_fsm #(
    parameter int unsigned MIN_ALPHA = 1,
    parameter int unsigned MAX_LEN   = 15,
    parameter int unsigned LEN_W     = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    id_scan_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALPHA = 2'd1,
        ST_DIGIT = 2'd2,
        ST_BAD   = 2'd3
    } state_e;

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] MIN_A = LEN_W'(MIN_ALPHA);
    localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [LEN_W-1:0] alen_q, alen_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             match_q, match_d;
    logic             tok_done_q, tok_done_d;
    logic [LEN_W-1:0] tok_len_q, tok_len_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

    logic is_letter;
    logic is_digit;
    logic len_full;

    // Character classification; anything not a letter or digit is a separator.
    always_comb begin
        is_letter = ((bus.char >= 8'd65) && (bus.char <= 8'd90)) ||
                    ((bus.char >= 8'd97) && (bus.char <= 8'd122));
`ifdef ID_UNDERSCORE_EN
        if (bus.char == 8'd95) begin
            is_letter = 1'b1;
        end
`else
`endif
        is_digit = (bus.char >= 8'd48) && (bus.char <= 8'd57);
        len_full = (len_q >= MAX_L);
    end

    // State register with alpha and token length counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            alen_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            alen_q  <= alen_d;
            len_q   <= len_d;
        end
    end

    // Next-state and counter update; only consumed characters advance the scan.
    always_comb begin
        state_d = state_q;
        alen_d  = alen_q;
        len_d   = len_q;
        if (bus.char_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (is_letter) begin
                        state_d = ST_ALPHA;
                        alen_d  = ONE_L;
                        len_d   = ONE_L;
                    end else if (is_digit) begin
                        state_d = ST_BAD;
                    end
                end
                ST_ALPHA: begin
                    if (is_letter) begin
                        if (len_full) begin
                            state_d = ST_BAD;
                        end else begin
                            len_d  = len_q + ONE_L;
                            alen_d = (alen_q < MAX_L) ? alen_q + ONE_L : alen_q;
                        end
                    end else if (is_digit) begin
                        if (len_full || (alen_q < MIN_A)) begin
                            state_d = ST_BAD;
                        end else begin
                            state_d = ST_DIGIT;
                            len_d   = len_q + ONE_L;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        alen_d  = '0;
                        len_d   = '0;
                    end
                end
                ST_DIGIT: begin
                    if (is_digit) begin
                        if (len_full) begin
                            state_d = ST_BAD;
                        end else begin
                            len_d = len_q + ONE_L;
                        end
                    end else if (is_letter) begin
                        state_d = ST_BAD;
                    end else begin
                        state_d = ST_IDLE;
                        alen_d  = '0;
                        len_d   = '0;
                    end
                end
                ST_BAD: begin
                    if (!is_letter && !is_digit) begin
                        state_d = ST_IDLE;
                        alen_d  = '0;
                        len_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    alen_d  = '0;
                    len_d   = '0;
                end
            endcase
        end
    end

    // Output next values: token-end pulse, held length, saturating match count.
    always_comb begin
        match_d     = (state_d == ST_DIGIT);
        tok_done_d  = 1'b0;
        tok_len_d   = tok_len_q;
        match_cnt_d = match_cnt_q;
        if (bus.char_valid && (state_q == ST_DIGIT) && !is_letter && !is_digit) begin
            tok_done_d = 1'b1;
            tok_len_d  = len_q;
            if (match_cnt_q != CNT_MAX) begin
                match_cnt_d = match_cnt_q + CNT_W'(1);
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match_q     <= 1'b0;
            tok_done_q  <= 1'b0;
            tok_len_q   <= '0;
            match_cnt_q <= '0;
        end else begin
            match_q     <= match_d;
            tok_done_q  <= tok_done_d;
            tok_len_q   <= tok_len_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign bus.match     = match_q;
    assign bus.tok_done  = tok_done_q;
    assign bus.tok_len   = tok_len_q;
    assign bus.match_cnt = match_cnt_q;

endmodule
